px_burst_writer: RTL and testbench

- AXI4 burst write master: the write-back stage directly downstream of the BRAM loader / pixel-conversion path.
- Consumes converted 32-bit pixel words on a valid/ready stream.
- Writes them to DDR as INCR bursts starting at a programmed destination address, then signals done.
- Mirrors the read master's AXI conventions so both sit on the same interconnect port.

---
 rtl/px_axi_pkg.sv | 44 ++++
 rtl/px_burst_writer.sv | 189 ++++++++++++++++++
 tb/tb_px_burst_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/px_axi_pkg.sv
// ---------------------------------------------------------------------------
// px_axi_pkg
// Shared AXI4 constants and write-master state encoding. The read master
// imports the same package, so both masters present identical AxCACHE/AxPROT
// attributes on the shared interconnect port.
//
// Contents:
//   PX_ST_*      write-master state codes (3-bit)
//   AXSIZE_4B    4-byte beat size
//   BURST_INCR   incrementing burst type
//   RESP_OKAY    OKAY response code
//   AXCACHE_DEF  bufferable/modifiable, no allocate
//   AXPROT_DEF   unprivileged, secure, data access
//   WSTRB_FULL   all byte lanes valid
//   px_burst_len() beats for the next burst: min(max_beats, remaining)
// ---------------------------------------------------------------------------
package px_axi_pkg;

    typedef logic [2:0] px_state_t;

    localparam px_state_t PX_ST_IDLE = 3'd0;
    localparam px_state_t PX_ST_AW   = 3'd1;
    localparam px_state_t PX_ST_W    = 3'd2;
    localparam px_state_t PX_ST_B    = 3'd3;
    localparam px_state_t PX_ST_DONE = 3'd4;

    localparam logic [2:0] AXSIZE_4B   = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [3:0] AXCACHE_DEF = 4'b0011;
    localparam logic [2:0] AXPROT_DEF  = 3'b000;
    localparam logic [3:0] WSTRB_FULL  = 4'hF;

    // Beat count of the next burst. Both operands are widened to 32 bits so
    // the caller's counter width does not matter; the result fits in 9 bits
    // because a burst never exceeds 256 beats.
    function automatic logic [8:0] px_burst_len(input logic [31:0] remaining,
                                                input logic [31:0] max_beats);
        logic [31:0] pick;
        pick = (remaining < max_beats) ? remaining : max_beats;
        return pick[8:0];
    endfunction

endpackage

// File: rtl/px_burst_writer.sv
// ---------------------------------------------------------------------------
// px_burst_writer
// AXI4 burst write master for the pixel write-back path. Takes 32-bit words
// from a valid/ready stream and writes them to DDR as INCR bursts of up to
// BURST_LEN beats starting at dst_addr, then pulses done.
//
// Ports:
//   m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//   start, dst_addr, num_words job request (pulse), latched when idle
//   busy, done, md_error       job status; md_error is sticky per job
//   s_tdata/s_tvalid/s_tready  pixel word stream in
//   m_axi_aw*                  write address channel
//   m_axi_w*                   write data channel (wdata passes s_tdata)
//   m_axi_b*                   write response channel
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start
// AW    | first cycle loads burst address/length, then holds awvalid
// W     | streaming len beats, stream and W channel joined combinationally
// B     | waiting for the write response, then advances address/remaining
// DONE  | one-cycle done pulse, drops busy
// ---------------------------------------------------------------------------
module px_burst_writer
    import px_axi_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 24
) (
    input  logic             m_axi_aclk,
    input  logic             m_axi_areset,

    input  logic             start,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] num_words,
    output logic             busy,
    output logic             done,
    output logic             md_error,

    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,

    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_awaddr,
    output logic [7:0]       m_axi_awlen,
    output logic [2:0]       m_axi_awsize,
    output logic [1:0]       m_axi_awburst,
    output logic [2:0]       m_axi_awprot,
    output logic [3:0]       m_axi_awcache,

    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    output logic             m_axi_wlast,

    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    input  logic [1:0]       m_axi_bresp
);

    localparam logic [31:0] MAX_BEATS = 32'(BURST_LEN);

    px_state_t        state;
    logic [31:0]      addr;
    logic [CNT_W-1:0] rem;
    logic [8:0]       len;
    logic [8:0]       beat;
    logic             awvalid_q;
    logic [31:0]      awaddr_q;
    logic [7:0]       awlen_q;
    logic             busy_q;
    logic             done_q;
    logic             md_error_q;

    logic [8:0]       len_next;
    logic             in_w;
    logic             last_beat;
    logic             w_fire;
    logic             last_burst;
    logic [31:0]      addr_step;

    assign len_next   = px_burst_len(32'(rem), MAX_BEATS);
    assign in_w       = (state == PX_ST_W);
    assign last_beat  = in_w && (beat == (len - 9'd1));
    assign w_fire     = in_w && s_tvalid && m_axi_wready;
    assign last_burst = (rem == CNT_W'(len));
    assign addr_step  = {21'd0, len, 2'b00};

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state      <= PX_ST_IDLE;
            addr       <= '0;
            rem        <= '0;
            len        <= '0;
            beat       <= '0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            md_error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                PX_ST_IDLE: begin
                    if (start) begin
                        addr       <= dst_addr;
                        rem        <= num_words;
                        md_error_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= (num_words == '0) ? PX_ST_DONE : PX_ST_AW;
                    end
                end

                PX_ST_AW: begin
                    // The setup cycle registers the address beat so awaddr and
                    // awlen come straight from flops while awvalid is high.
                    if (!awvalid_q) begin
                        awaddr_q  <= addr;
                        awlen_q   <= 8'(len_next - 9'd1);
                        len       <= len_next;
                        awvalid_q <= 1'b1;
                    end else if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        beat      <= '0;
                        state     <= PX_ST_W;
                    end
                end

                PX_ST_W: begin
                    if (w_fire) begin
                        beat <= beat + 9'd1;
                        if (last_beat) begin
                            state <= PX_ST_B;
                        end
                    end
                end

                PX_ST_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != RESP_OKAY) begin
                            md_error_q <= 1'b1;
                        end
                        // len never exceeds rem, so this cannot underflow.
                        rem   <= rem - CNT_W'(len);
                        addr  <= addr + addr_step;
                        state <= last_burst ? PX_ST_DONE : PX_ST_AW;
                    end
                end

                PX_ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= PX_ST_IDLE;
                end

                default: begin
                    state <= PX_ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign md_error      = md_error_q;

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AXSIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awprot  = AXPROT_DEF;
    assign m_axi_awcache = AXCACHE_DEF;

    // Stream and W channel are joined only in W, so no beat can leave before
    // its address has been accepted and bursts never overlap.
    assign m_axi_wvalid  = in_w & s_tvalid;
    assign s_tready      = in_w & m_axi_wready;
    assign m_axi_wdata   = s_tdata;
    assign m_axi_wstrb   = WSTRB_FULL;
    assign m_axi_wlast   = last_beat;

    assign m_axi_bready  = (state == PX_ST_B);

endmodule

// File: tb/tb_px_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_px_burst_writer
// Drives jobs into px_burst_writer with a randomized stream source and AXI
// slave, and compares the DUT each cycle against a job-level model: the list
// of bursts a job must produce, the word order, and the done/busy/md_error
// timing relative to start and the final write response.
// ---------------------------------------------------------------------------
module tb_px_burst_writer;

    localparam int BL = 16;
    localparam int CW = 24;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_areset;
    logic          start;
    logic [31:0]   dst_addr;
    logic [CW-1:0] num_words;
    logic          busy, done, md_error;
    logic [31:0]   s_tdata;
    logic          s_tvalid, s_tready;
    logic          m_axi_awvalid, m_axi_awready;
    logic [31:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic [2:0]    m_axi_awprot;
    logic [3:0]    m_axi_awcache;
    logic          m_axi_wvalid, m_axi_wready;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_bvalid, m_axi_bready;
    logic [1:0]    m_axi_bresp;

    px_burst_writer #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_areset (m_axi_areset),
        .start        (start),
        .dst_addr     (dst_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .md_error     (md_error),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awcache(m_axi_awcache),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_bresp  (m_axi_bresp)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus knobs ----------------
    int   gap_pct = 0;
    int   err_abs = -1;     // absolute B-response index that returns SLVERR
    bit   chk_en  = 1'b0;

    function automatic bit pass();
        return $urandom_range(99) >= gap_pct;
    endfunction

    // ---------------- stream source and AXI slave ----------------
    int          b_count = 0;
    logic [31:0] word = 32'd0;

    initial begin
        bit src_hs, last_hs, b_hs, rst_s, b_owed;
        s_tvalid = 1'b0; s_tdata = 32'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        b_owed = 1'b0;
        forever begin
            @(negedge m_axi_aclk);
            src_hs  = s_tvalid && s_tready && !m_axi_areset;
            last_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast && !m_axi_areset;
            b_hs    = m_axi_bvalid && m_axi_bready && !m_axi_areset;
            rst_s   = m_axi_areset;
            @(posedge m_axi_aclk);
            #1;
            if (src_hs) word = word + 32'd1;
            if (!s_tvalid || src_hs) s_tvalid = pass();
            s_tdata       = word;
            m_axi_awready = pass();
            m_axi_wready  = pass();
            if (b_hs) begin
                m_axi_bvalid = 1'b0;
                b_count++;
            end
            if (rst_s) begin
                m_axi_bvalid = 1'b0;
                b_owed = 1'b0;
            end
            if (last_hs) b_owed = 1'b1;
            if (b_owed && !m_axi_bvalid && pass()) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_count == err_abs) ? 2'b10 : 2'b00;
                b_owed = 1'b0;
            end
        end
    end

    // ---------------- job-level model and per-cycle compare ----------------
    bit          job_active, w_open, b_pending, exp_md, prev_stall;
    logic [31:0] q_addr[$];
    int          q_len[$];
    int          cur_len, beat_idx, fin, cyc;
    logic [31:0] exp_word = 32'd0;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    int          job_beats, job_busy_cycles, start_cyc, done_cyc;
    logic [31:0] aw_log_addr[$];
    int          aw_log_len[$];
    int          wlast_log[$];

    initial begin
        bit exp_done, wo, bp;
        logic [31:0] a;
        int r, l;
        job_active = 0; w_open = 0; b_pending = 0; exp_md = 0; prev_stall = 0;
        fin = 0; cyc = 0; cur_len = 0; beat_idx = 0;
        forever begin
            @(negedge m_axi_aclk);
            cyc++;
            if (chk_en) begin
                exp_done = (fin == 1);
                if (fin > 0) fin--;
                if (exp_done) job_active = 0;
                chk("done", 32'(done), 32'(exp_done));
                if (done) done_cyc = cyc;
                chk("busy", 32'(busy), 32'(job_active));
                if (busy) job_busy_cycles++;
                chk("md_error", 32'(md_error), 32'(exp_md));
                chk("wvalid", 32'(m_axi_wvalid), 32'(w_open & s_tvalid));
                chk("s_tready", 32'(s_tready), 32'(w_open & m_axi_wready));
                chk("bready", 32'(m_axi_bready), 32'(b_pending));
                if (m_axi_awvalid) begin
                    chk("aw_legal", 32'(!w_open && !b_pending && job_active && q_len.size() > 0), 32'd1);
                    if (q_len.size() > 0) begin
                        chk("awaddr", m_axi_awaddr, q_addr[0]);
                        chk("awlen", 32'(m_axi_awlen), 32'(q_len[0] - 1));
                    end
                    chk("aw_consts", {m_axi_awsize, m_axi_awburst, m_axi_awprot, m_axi_awcache},
                        {3'b010, 2'b01, 3'b000, 4'b0011});
                end
                if (prev_stall) begin
                    chk("aw_hold_valid", 32'(m_axi_awvalid), 32'd1);
                    chk("aw_hold_addr", m_axi_awaddr, prev_awaddr);
                    chk("aw_hold_len", 32'(m_axi_awlen), 32'(prev_awlen));
                end
                if (m_axi_wvalid && w_open) begin
                    chk("wlast", 32'(m_axi_wlast), 32'(beat_idx == cur_len - 1));
                    chk("wstrb", 32'(m_axi_wstrb), 32'hF);
                end
                if (m_axi_wvalid && m_axi_wready && w_open)
                    chk("wdata", m_axi_wdata, exp_word);

                if (m_axi_areset) begin
                    job_active = 0; w_open = 0; b_pending = 0; exp_md = 0;
                    fin = 0; prev_stall = 0;
                    q_addr.delete(); q_len.delete();
                end else begin
                    wo = w_open;
                    bp = b_pending;
                    prev_stall  = m_axi_awvalid && !m_axi_awready;
                    prev_awaddr = m_axi_awaddr;
                    prev_awlen  = m_axi_awlen;
                    if (m_axi_bvalid && bp) begin
                        b_pending = 0;
                        if (m_axi_bresp != 2'b00) exp_md = 1;
                        if (q_len.size() == 0) fin = 2;
                    end
                    if (m_axi_wvalid && m_axi_wready && wo) begin
                        if (beat_idx == cur_len - 1) begin
                            wlast_log.push_back(job_beats);
                            w_open = 0;
                            b_pending = 1;
                        end
                        beat_idx++;
                        job_beats++;
                        exp_word = exp_word + 32'd1;
                    end
                    if (m_axi_awvalid && m_axi_awready && !wo && !bp && q_len.size() > 0) begin
                        aw_log_addr.push_back(m_axi_awaddr);
                        aw_log_len.push_back(int'(m_axi_awlen));
                        cur_len = q_len.pop_front();
                        void'(q_addr.pop_front());
                        w_open = 1;
                        beat_idx = 0;
                    end
                    if (start && !job_active) begin
                        job_active = 1;
                        exp_md = 0;
                        aw_log_addr.delete(); aw_log_len.delete(); wlast_log.delete();
                        job_beats = 0; job_busy_cycles = 0; start_cyc = cyc;
                        a = dst_addr;
                        r = int'(num_words);
                        while (r > 0) begin
                            l = (r < BL) ? r : BL;
                            q_addr.push_back(a);
                            q_len.push_back(l);
                            a = a + 32'(l * 4);
                            r = r - l;
                        end
                        if (num_words == '0) fin = 2;
                    end
                end
            end
        end
    end

    // ---------------- job sequencing ----------------
    task automatic run_job(input logic [31:0] base, input int n, input int gap, input bit poke);
        bit got;
        gap_pct = gap;
        @(posedge m_axi_aclk); #1;
        start = 1'b1; dst_addr = base; num_words = CW'(n);
        @(posedge m_axi_aclk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (5) @(posedge m_axi_aclk);
            #1;
            start = 1'b1; dst_addr = 32'h7000_0000; num_words = CW'(7);
            @(posedge m_axi_aclk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge m_axi_aclk);
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
        repeat (2) @(posedge m_axi_aclk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        m_axi_areset = 1'b1;
        start = 1'b0; dst_addr = 32'd0; num_words = '0;
        @(posedge m_axi_aclk); #1;
        chk_en = 1'b1;
        @(negedge m_axi_aclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_md_error", 32'(md_error), 32'd0);
        chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("rst_awaddr", m_axi_awaddr, 32'd0);
        chk("rst_awlen", 32'(m_axi_awlen), 32'd0);
        chk("rst_wvalid_wlast", 32'({m_axi_wvalid, m_axi_wlast}), 32'd0);
        chk("rst_bready_tready", 32'({m_axi_bready, s_tready}), 32'd0);
        @(posedge m_axi_aclk); #1;
        m_axi_areset = 1'b0;

        // 32 words, everything ready: two full bursts, 16+3 cycles each.
        run_job(32'h1000_0000, 32, 0, 1'b0);
        chk("j1_bursts", 32'(aw_log_addr.size()), 32'd2);
        if (aw_log_addr.size() == 2) begin
            chk("j1_awaddr0", aw_log_addr[0], 32'h1000_0000);
            chk("j1_awaddr1", aw_log_addr[1], 32'h1000_0040);
            chk("j1_awlen0", 32'(aw_log_len[0]), 32'd15);
            chk("j1_awlen1", 32'(aw_log_len[1]), 32'd15);
        end
        chk("j1_wlasts", 32'(wlast_log.size()), 32'd2);
        if (wlast_log.size() == 2) begin
            chk("j1_wlast0", 32'(wlast_log[0]), 32'd15);
            chk("j1_wlast1", 32'(wlast_log[1]), 32'd31);
        end
        chk("j1_latency", 32'(done_cyc - start_cyc), 32'd40);
        chk("j1_md_error", 32'(md_error), 32'd0);

        // 20 words: full burst then a 4-beat partial.
        run_job(32'h2000_0000, 20, 0, 1'b0);
        chk("j2_bursts", 32'(aw_log_addr.size()), 32'd2);
        if (aw_log_addr.size() == 2) begin
            chk("j2_awaddr1", aw_log_addr[1], 32'h2000_0040);
            chk("j2_awlen0", 32'(aw_log_len[0]), 32'd15);
            chk("j2_awlen1", 32'(aw_log_len[1]), 32'd3);
        end
        if (wlast_log.size() == 2) chk("j2_wlast1", 32'(wlast_log[1]), 32'd19);
        else chk("j2_wlasts", 32'(wlast_log.size()), 32'd2);

        // 48 words with 30% gaps on both sides; a second start mid-job is ignored.
        run_job(32'h3000_0000, 48, 30, 1'b1);
        chk("j3_beats", 32'(job_beats), 32'd48);

        // SLVERR on the second of three bursts.
        err_abs = b_count + 1;
        run_job(32'h3000_1000, 48, 10, 1'b0);
        chk("j4_md_error", 32'(md_error), 32'd1);
        err_abs = -1;
        run_job(32'h3000_2000, 16, 0, 1'b0);
        chk("j5_md_cleared", 32'(md_error), 32'd0);

        // Zero-length job: no address phase, one busy cycle, done two cycles on.
        run_job(32'h3000_3000, 0, 0, 1'b0);
        chk("j6_no_aw", 32'(aw_log_addr.size()), 32'd0);
        chk("j6_busy_cycles", 32'(job_busy_cycles), 32'd1);
        chk("j6_latency", 32'(done_cyc - start_cyc), 32'd2);

        // Reset in the middle of the first burst, then a clean job.
        gap_pct = 0;
        @(posedge m_axi_aclk); #1;
        start = 1'b1; dst_addr = 32'h4000_0000; num_words = CW'(32);
        @(posedge m_axi_aclk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge m_axi_aclk);
            if (job_beats >= 5) got = 1'b1;
        end
        chk("j7_reached_beat5", 32'(got), 32'd1);
        @(posedge m_axi_aclk); #1;
        m_axi_areset = 1'b1;
        @(posedge m_axi_aclk); #1;
        m_axi_areset = 1'b0;
        @(negedge m_axi_aclk);
        chk("j7_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("j7_busy", 32'(busy), 32'd0);
        chk("j7_awvalid", 32'(m_axi_awvalid), 32'd0);
        run_job(32'h4000_0400, 16, 0, 1'b0);
        chk("j8_beats", 32'(job_beats), 32'd16);
        if (aw_log_addr.size() == 1) chk("j8_awaddr", aw_log_addr[0], 32'h4000_0400);
        else chk("j8_bursts", 32'(aw_log_addr.size()), 32'd1);

        // Random jobs.
        for (int k = 0; k < 6; k++) begin
            int n;
            logic [31:0] base;
            n = $urandom_range(70, 1);
            base = $urandom() & 32'hFFFF_FFC0;
            run_job(base, n, $urandom_range(40, 0), 1'b0);
            chk("rand_beats", 32'(job_beats), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
